// File: rtl/encoder_pkg.sv
// Shared widths, FSM state encoding and mask helper for the 8-way priority encoder.
package encoder_pkg;

  localparam int ENC_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Expand a binary request index into the matching single-bit mask.
  function automatic logic [ENC_W-1:0] onehot3(input logic [CODE_W-1:0] code);
    onehot3 = {{(ENC_W-1){1'b0}}, 1'b1} << code;
  endfunction

endpackage

// File: rtl/pick_first8.sv
// Combinational search: first set bit of vec, scanning upward from start and wrapping 7 -> 0.
module pick_first8
  import encoder_pkg::*;
(
  input  logic [ENC_W-1:0]  vec,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  logic [CODE_W-1:0] cand;

  // Walk the eight positions from start, keeping the first hit; the 3-bit add wraps naturally.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < ENC_W; i++) begin
      cand = start + i[CODE_W-1:0];
      if (!any && vec[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_encoder8.sv
// Sticky 8-line request collector that offers one binary index at a time over VALID/READY.
// ROTATE=0 picks the lowest pending index; ROTATE=1 searches round-robin after the last grant.
module priority_encoder8
  import encoder_pkg::*;
#(
  parameter bit ROTATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ENC_W-1:0]  req,
  input  logic              clr,
  input  logic              ready,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic [ENC_W-1:0]  pending,
  output logic              overrun
);

  state_t            state;
  logic [CODE_W-1:0] last_ptr;
  logic [CODE_W-1:0] start;
  logic [CODE_W-1:0] sel_idx;
  logic              sel_any;
  logic              accept;
  logic [ENC_W-1:0]  ack_mask;

  // A clear in the same cycle as READY cancels the acknowledge entirely.
  assign accept   = (state == OFFER) && ready && !clr;
  assign ack_mask = accept ? onehot3(code) : '0;
  assign start    = ROTATE ? (last_ptr + 3'd1) : '0;

  pick_first8 u_pick (
    .vec   (pending),
    .start (start),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // Pending set and overrun flag: new requests beat the acknowledge of the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= 1'b0;
    end else if (clr) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~ack_mask) | req;
      overrun <= |(req & pending & ~ack_mask);
    end
  end

  // Offer FSM: select from the registered pending set, hold the offer until accepted or cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid    <= 1'b0;
      code     <= '0;
      last_ptr <= 3'd7;
    end else begin
      case (state)
        IDLE: begin
          if (!clr && sel_any) begin
            code  <= sel_idx;
            valid <= 1'b1;
            state <= OFFER;
          end
        end
        OFFER: begin
          if (clr) begin
            valid <= 1'b0;
            state <= IDLE;
          end else if (ready) begin
            valid    <= 1'b0;
            last_ptr <= code;
            state    <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_encoder8.sv
// Directed bench: one fixed-priority and one round-robin encoder driven by the same inputs.
module tb_priority_encoder8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       clr;
  logic       ready;
  logic       valid0, valid1;
  logic [2:0] code0, code1;
  logic [7:0] pending0, pending1;
  logic       overrun0, overrun1;

  int checks;
  int failures;

  priority_encoder8 #(.ROTATE(1'b0)) u_fixed (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .clr     (clr),
    .ready   (ready),
    .valid   (valid0),
    .code    (code0),
    .pending (pending0),
    .overrun (overrun0)
  );

  priority_encoder8 #(.ROTATE(1'b1)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .clr     (clr),
    .ready   (ready),
    .valid   (valid1),
    .code    (code1),
    .pending (pending1),
    .overrun (overrun1)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Linear sequence of directed steps with hand-computed expectations.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 8'h00;
    clr      = 1'b0;
    ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset with no requests.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("idle_valid0", valid0, 1'b0);
      chk1("idle_valid1", valid1, 1'b0);
      chk8("idle_pending0", pending0, 8'h00);
      chk1("idle_overrun0", overrun0, 1'b0);
    end

    // Two requests in one pulse, drained lowest first with a bubble between grants.
    ready = 1'b1;
    req   = 8'h28;
    tick();
    chk8("t2_pend_a", pending0, 8'h28);
    chk1("t2_valid_a", valid0, 1'b0);
    req = 8'h00;
    tick();
    chk1("t2_valid_b", valid0, 1'b1);
    chk3("t2_code0_b", code0, 3'd3);
    chk3("t2_code1_b", code1, 3'd3);
    chk8("t2_pend_b", pending0, 8'h28);
    tick();
    chk1("t2_valid_c", valid0, 1'b0);
    chk8("t2_pend_c", pending0, 8'h20);
    tick();
    chk1("t2_valid_d", valid0, 1'b1);
    chk3("t2_code0_d", code0, 3'd5);
    chk3("t2_code1_d", code1, 3'd5);
    tick();
    chk1("t2_valid_e", valid0, 1'b0);
    chk8("t2_pend_e", pending0, 8'h00);

    // Prime last_ptr=0 with a grant of 0, then 8'h81 shows rotation versus fixed order.
    req = 8'h01;
    tick();
    req = 8'h00;
    tick();
    chk1("t3_prime_valid", valid1, 1'b1);
    chk3("t3_prime_code", code1, 3'd0);
    tick();
    chk8("t3_prime_pend", pending1, 8'h00);
    req = 8'h81;
    tick();
    chk8("t3_pend1_a", pending1, 8'h81);
    req = 8'h00;
    tick();
    chk1("t3_valid1_b", valid1, 1'b1);
    chk3("t3_code1_b", code1, 3'd7);
    chk3("t3_code0_b", code0, 3'd0);
    tick();
    chk8("t3_pend1_c", pending1, 8'h01);
    chk8("t3_pend0_c", pending0, 8'h80);
    tick();
    chk3("t3_code1_d", code1, 3'd0);
    chk3("t3_code0_d", code0, 3'd7);
    tick();
    chk8("t3_pend1_e", pending1, 8'h00);
    chk8("t3_pend0_e", pending0, 8'h00);

    // Re-request of the bit being accepted keeps it pending without overrun.
    ready = 1'b0;
    req   = 8'h04;
    tick();
    req = 8'h00;
    tick();
    chk1("t4_valid_a", valid0, 1'b1);
    chk3("t4_code0_a", code0, 3'd2);
    chk3("t4_code1_a", code1, 3'd2);
    ready = 1'b1;
    req   = 8'h04;
    tick();
    chk1("t4_overrun0", overrun0, 1'b0);
    chk1("t4_overrun1", overrun1, 1'b0);
    chk8("t4_pend", pending0, 8'h04);
    chk1("t4_valid_b", valid0, 1'b0);
    ready = 1'b0;
    req   = 8'h00;
    tick();
    chk1("t4_valid_c", valid0, 1'b1);
    chk3("t4_code0_c", code0, 3'd2);
    chk3("t4_code1_c", code1, 3'd2);

    // Re-request of a pending, unaccepted bit pulses overrun once.
    req = 8'h04;
    tick();
    chk1("t5_overrun0_a", overrun0, 1'b1);
    chk1("t5_overrun1_a", overrun1, 1'b1);
    chk8("t5_pend_a", pending0, 8'h04);
    chk1("t5_valid_a", valid0, 1'b1);
    chk3("t5_code_a", code0, 3'd2);
    req = 8'h00;
    tick();
    chk1("t5_overrun0_b", overrun0, 1'b0);
    chk8("t5_pend_b", pending0, 8'h04);
    ready = 1'b1;
    tick();
    chk8("t5_pend_c", pending0, 8'h00);
    chk1("t5_valid_c", valid0, 1'b0);
    ready = 1'b0;
    tick();
    chk1("t5_valid_d", valid0, 1'b0);

    // Clear beats READY during an offer of code 1; last_ptr stays at 2.
    req = 8'h02;
    tick();
    req = 8'h00;
    tick();
    chk1("t6_valid_a", valid0, 1'b1);
    chk3("t6_code0_a", code0, 3'd1);
    chk3("t6_code1_a", code1, 3'd1);
    clr   = 1'b1;
    ready = 1'b1;
    tick();
    chk1("t6_valid0_b", valid0, 1'b0);
    chk1("t6_valid1_b", valid1, 1'b0);
    chk8("t6_pend0_b", pending0, 8'h00);
    chk1("t6_overrun_b", overrun0, 1'b0);
    clr   = 1'b0;
    ready = 1'b0;
    req   = 8'h05;
    tick();
    req = 8'h00;
    tick();
    chk1("t6_valid1_c", valid1, 1'b1);
    chk3("t6_code1_c", code1, 3'd0);
    chk3("t6_code0_c", code0, 3'd0);

    // Asynchronous reset in the middle of an offer.
    #1;
    rst_n = 1'b0;
    #1;
    chk1("t6_rst_valid0", valid0, 1'b0);
    chk1("t6_rst_valid1", valid1, 1'b0);
    chk3("t6_rst_code0", code0, 3'd0);
    chk8("t6_rst_pend0", pending0, 8'h00);
    chk8("t6_rst_pend1", pending1, 8'h00);
    chk1("t6_rst_overrun", overrun0, 1'b0);
    tick();
    chk1("t6_rst_hold_valid", valid0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
